wind_conditioner: RTL and testbench

WIND_CONDITIONER -- requirements
Module: wind_conditioner

---
 rtl/wind_pkg.sv | 12 +
 rtl/wind_debounce.sv | 52 +++++
 rtl/wind_conditioner.sv | 68 ++++++
 tb/tb_wind_conditioner.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/wind_pkg.sv
// Shared wind-code types and constants.
// Imported by the wind conditioner and the downstream lights FSM.
package wind_pkg;

    typedef logic [0:1] wind_t;

    localparam wind_t WIND_CALM = 2'b00;
    localparam wind_t WIND_L2R  = 2'b01;
    localparam wind_t WIND_R2L  = 2'b10;
    localparam wind_t WIND_BAD  = 2'b11;

endpackage

// File: rtl/wind_debounce.sv
// Two-flop synchronizer followed by a whole-vector debouncer.
// A new code becomes stable after DEBOUNCE_CYCLES identical samples.
module wind_debounce
    import wind_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic  clk,
    input  logic  reset,
    input  wind_t raw,
    output wind_t stable
);

    localparam logic [15:0] LAST = 16'(DEBOUNCE_CYCLES - 1);

    wind_t       s1;
    wind_t       s2;
    wind_t       cand;
    logic [15:0] cnt;

    // Two-stage synchronizer for the asynchronous switch inputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= WIND_CALM;
            s2 <= WIND_CALM;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Count consecutive identical samples of a code that differs from stable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable <= WIND_CALM;
            cand   <= WIND_CALM;
            cnt    <= '0;
        end else if (s2 == stable) begin
            cand <= s2;
            cnt  <= '0;
        end else if (s2 != cand) begin
            cand <= s2;
            cnt  <= 16'd1;
        end else if (cnt == LAST) begin
            stable <= s2;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/wind_conditioner.sv
// Conditions raw wind switches into a stepped, validated wind code.
// Macro WIND_HOLD_EN: code 11 holds the previous w instead of forcing calm.
module wind_conditioner
    import wind_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TICK_DIV        = 8
) (
    input  logic  clk,
    input  logic  reset,
    input  wind_t sw_raw,
    output wind_t w,
    output logic  step,
    output logic  w_changed
);

    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TICK_DIV - 1);

    wind_t          stable;
    wind_t          w_next;
    logic [TW-1:0]  tcnt;
    logic           tick;

    wind_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
        .clk   (clk),
        .reset (reset),
        .raw   (sw_raw),
        .stable(stable)
    );

    assign tick = (tcnt == TLAST);

    // Free-running step divider; terminal count is the tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) tcnt <= '0;
        else if (tick) tcnt <= '0;
        else tcnt <= tcnt + 1'b1;
    end

    // Replace the invalid code before it can reach w
    always_comb begin
        w_next = stable;
        if (stable == WIND_BAD) begin
`ifdef WIND_HOLD_EN
            w_next = w;
`else
            w_next = WIND_CALM;
`endif
        end
    end

    // Update w only on the tick; step and change flag follow for one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w         <= WIND_CALM;
            step      <= 1'b0;
            w_changed <= 1'b0;
        end else begin
            step      <= tick;
            w_changed <= tick && (w_next != w);
            if (tick) w <= w_next;
        end
    end

endmodule

// File: tb/tb_wind_conditioner.sv
// Randomized self-checking bench for wind_conditioner.
// Reference model works on sample histories, not on RTL state.
module tb_wind_conditioner;
    import wind_pkg::*;

    localparam int DEB = 4;
    localparam int TDV = 8;

    logic  clk = 1'b0;
    logic  reset = 1'b1;
    wind_t sw_raw = WIND_CALM;
    wind_t w;
    logic  step;
    logic  w_changed;

    int errors = 0;
    int checks = 0;

    // model state
    int n;
    int rq[$];
    int sh[$];
    int st_m;
    int w_m;
    int step_m;
    int chg_m;

    wind_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .TICK_DIV(TDV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sw_raw   (sw_raw),
        .w        (w),
        .step     (step),
        .w_changed(w_changed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @edge %0d: got %0d expected %0d",
                     tag, n, got, exp);
        end
    endtask

    function automatic int map_code(input int s, input int prev);
        if (s != 3) return s;
`ifdef WIND_HOLD_EN
        return prev;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        n = 0;
        rq.delete();
        sh.delete();
        st_m = 0;
        w_m = 0;
        step_m = 0;
        chg_m = 0;
    endtask

    // One clock edge of the reference model with raw value v sampled
    task automatic model_edge(input int v);
        int samp;
        int last;
        bit same;
        int nw;
        n++;
        samp = (rq.size() >= 2) ? rq[rq.size() - 2] : 0;
        rq.push_back(v);
        if (rq.size() > 8) void'(rq.pop_front());
        step_m = ((n % TDV) == 0);
        chg_m = 0;
        if (step_m != 0) begin
            nw = map_code(st_m, w_m);
            chg_m = (nw != w_m);
            w_m = nw;
        end
        sh.push_back(samp);
        if (sh.size() > 2 * DEB) void'(sh.pop_front());
        if (sh.size() >= DEB) begin
            last = sh[sh.size() - 1];
            same = 1'b1;
            for (int k = 1; k < DEB; k++)
                if (sh[sh.size() - 1 - k] != last) same = 1'b0;
            if (same && last != st_m) st_m = last;
        end
    endtask

    task automatic cyc(input wind_t v);
        sw_raw = v;
        @(posedge clk);
        model_edge(int'(v));
        #1;
        check("stable", int'(dut.u_deb.stable), st_m);
        check("w", int'(w), w_m);
        check("step", int'(step), step_m);
        check("w_changed", int'(w_changed), chg_m);
        check("w_not_bad", int'(w == WIND_BAD), 0);
    endtask

    task automatic hold(input wind_t v, input int cycles);
        for (int i = 0; i < cycles; i++) cyc(v);
    endtask

    // Asynchronous reset between edges, then release before a negedge
    task automatic async_reset();
        #2;
        reset = 1'b1;
        #1;
        check("rst_w", int'(w), 0);
        check("rst_step", int'(step), 0);
        check("rst_chg", int'(w_changed), 0);
        check("rst_stable", int'(dut.u_deb.stable), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("init_w", int'(w), 0);
        check("init_step", int'(step), 0);
        reset = 1'b0;

        // Release with 01 held: stable at edge 6, first step at edge 8
        hold(WIND_L2R, 24);

        // Short glitch must be rejected
        hold(WIND_CALM, 24);
        hold(WIND_R2L, 3);
        hold(WIND_CALM, 24);

        // Chattering between 01 and 10 keeps w
        hold(WIND_R2L, 24);
        for (int i = 0; i < 20; i++) begin
            cyc(WIND_L2R);
            cyc(WIND_R2L);
        end
        hold(WIND_R2L, 16);

        // Invalid code after w=10
        hold(WIND_BAD, 20);
        hold(WIND_CALM, 24);

        // Acceptance lands exactly on a tick cycle
        while ((n % TDV) != 1) cyc(WIND_CALM);
        hold(WIND_R2L, 10);
        check("tick_accept_w", int'(w), int'(WIND_R2L));
        hold(WIND_CALM, 24);

        // Randomized run of variable-length holds
        for (int i = 0; i < 60; i++) begin
            wind_t v;
            v = wind_t'($urandom_range(0, 3));
            hold(v, int'($urandom_range(1, 12)));
        end

        // Reset in the middle of a debounce count and a tick period
        hold(WIND_CALM, 20);
        hold(WIND_L2R, 3);
        async_reset();
        hold(WIND_R2L, 20);

        // Reset right after a step
        while ((n % TDV) != 0) cyc(WIND_R2L);
        async_reset();
        hold(WIND_L2R, 18);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
